// File: rtl/neopix_pkg.sv
// Shared constants and types for the SPI pixel loader: byte-phase codes,
// FSM state encoding and the input synchronizer depth.
package neopix_pkg;

    localparam logic [1:0] PH_R = 2'd0;
    localparam logic [1:0] PH_G = 2'd1;
    localparam logic [1:0] PH_B = 2'd2;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_PEND  = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_dpram.sv
// Two-bank pixel store: one write port, one registered read port.
// Written with no reset on the array or read register so it maps onto block RAM.
module pixel_dpram #(
    parameter int DW    = 24,
    parameter int ABITS = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [ABITS-1:0] raddr,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem [2**ABITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/spi_pixel_loader.sv
// SPI-slave RGB frame receiver feeding a double-buffered pixel RAM that the
// NeoPixel serializer reads; swaps banks and strobes start once a good frame lands.
module spi_pixel_loader
    import neopix_pkg::*;
#(
    parameter  int NUM_LEDS = 8,
    localparam int AW       = $clog2(NUM_LEDS)
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          spi_sclk_i,
    input  logic          spi_mosi_i,
    input  logic          spi_cs_ni,
    input  logic          busy_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    red_o,
    output logic [7:0]    green_o,
    output logic [7:0]    blue_o,
    output logic [AW-1:0] led_count_o,
    output logic          start_o,
    output logic          frame_err_o
);

    localparam logic [AW-1:0] PTR_MAX = '1;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic sclk_d, cs_d, sclk_s, mosi_s, cs_s;
    logic sclk_rise, cs_fall, cs_rise;

    state_t        state, state_next;
    logic          swap, set_err, good;
    logic          disp_bank, rd_valid, ovf;
    logic [2:0]    bit_cnt;
    logic [1:0]    phase;
    logic [6:0]    shift;
    logic [7:0]    r_lat, g_lat, rx_byte;
    logic [AW-1:0] wr_ptr;
    logic          bit_done, we;
    logic [23:0]   rdata;

    // CS synchronizer resets high so reset release never looks like a CS edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    assign bit_done = (state == ST_RECV) && sclk_rise && !cs_s && (bit_cnt == 3'd7);
    assign rx_byte  = {shift, mosi_s};
    assign we       = bit_done && (phase == PH_B) && (wr_ptr != PTR_MAX);

    // Pointer and overflow only restart when a frame is accepted (IDLE); a frame
    // started in CHECK/PEND is dropped and must not disturb the pending count.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bit_cnt <= '0;
            phase   <= PH_R;
            shift   <= '0;
            r_lat   <= '0;
            g_lat   <= '0;
            wr_ptr  <= '0;
            ovf     <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt <= '0;
            phase   <= PH_R;
            if (state == ST_IDLE) begin
                wr_ptr <= '0;
                ovf    <= 1'b0;
            end
        end else if ((state == ST_RECV) && sclk_rise && !cs_s) begin
            shift   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                case (phase)
                    PH_R: begin
                        r_lat <= rx_byte;
                        phase <= PH_G;
                    end
                    PH_G: begin
                        g_lat <= rx_byte;
                        phase <= PH_B;
                    end
                    default: begin
                        phase <= PH_R;
                        if (wr_ptr == PTR_MAX) begin
                            ovf <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign good = (phase == PH_R) && !ovf && (wr_ptr != '0);

    always_comb begin
        state_next = state;
        swap       = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE:  if (cs_fall) state_next = ST_RECV;
            ST_RECV:  if (cs_rise) state_next = ST_CHECK;
            ST_CHECK: begin
                if (good) begin
                    state_next = ST_PEND;
                end else begin
                    state_next = ST_IDLE;
                    set_err    = 1'b1;
                end
            end
            ST_PEND: begin
                if (!busy_i) begin
                    swap       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= ST_IDLE;
            disp_bank   <= 1'b0;
            led_count_o <= '0;
            start_o     <= 1'b0;
            frame_err_o <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            state    <= state_next;
            start_o  <= swap;
            rd_valid <= 1'b1;
            if (swap) begin
                disp_bank   <= ~disp_bank;
                led_count_o <= wr_ptr;
                frame_err_o <= 1'b0;
            end else if (set_err) begin
                frame_err_o <= 1'b1;
            end
        end
    end

    pixel_dpram #(
        .DW    (24),
        .ABITS (AW + 1)
    ) u_ram (
        .clk   (clk_i),
        .we    (we),
        .waddr ({~disp_bank, wr_ptr}),
        .wdata ({r_lat, g_lat, rx_byte}),
        .raddr ({disp_bank, rd_addr_i}),
        .rdata (rdata)
    );

    // The RAM read register has no reset; hold the colour outputs at zero until
    // the first read after reset has completed.
    assign {red_o, green_o, blue_o} = rd_valid ? rdata : 24'h0;

endmodule
